ksa_wide_seq: RTL and testbench

- Multi-cycle wide add/subtract sequencer built around one shared 16-bit Kogge-Stone adder slice, ksa_16bit.
- Adds or subtracts WORDS×16-bit operands, one 16-bit word per cycle from LSW to MSW, with a registered carry chained between words.
- Valid/ready handshake on both sides; sits between the operand source and the result consumer in the arithmetic datapath.

---
 rtl/ksa_pkg.sv | 22 ++
 rtl/ksa_16bit.sv | 46 ++++
 rtl/ksa_wide_seq.sv | 136 +++++++++++++
 tb/tb_ksa_wide_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared definitions for the wide add/subtract sequencer.
//   WORD_W  : width of one adder slice
//   state_e : sequencer FSM states
//   ovf_f   : two's-complement overflow from the MSBs of A, effective B and S
package ksa_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // b_msb is the MSB after the subtract inversion, so the same rule covers
  // add and subtract.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb,
                                 input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/ksa_16bit.sv
// 16-bit Kogge-Stone adder slice, purely combinational.
//   a, b : operand words
//   ci   : carry in
//   s    : sum word
//   co   : carry out of bit WORD_W-1
module ksa_16bit
  import ksa_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  localparam int LVLS = $clog2(WORD_W);

  logic [LVLS:0][WORD_W-1:0] g;
  logic [LVLS:0][WORD_W-1:0] p;

  always_comb begin
    g = '0;
    p = '0;
    g[0] = a & b;
    p[0] = a ^ b;
    // Fold the carry-in into bit 0's generate so the prefix tree yields
    // carries that already include ci.
    g[0][0] = g[0][0] | (p[0][0] & ci);
    for (int l = 1; l <= LVLS; l++) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (i >= (1 << (l - 1))) begin
          g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i - (1 << (l - 1))]);
          p[l][i] = p[l-1][i] & p[l-1][i - (1 << (l - 1))];
        end else begin
          g[l][i] = g[l-1][i];
          p[l][i] = p[l-1][i];
        end
      end
    end
  end

  // g[LVLS][i] is the carry out of bit i.
  assign s  = p[0] ^ {g[LVLS][WORD_W-2:0], ci};
  assign co = g[LVLS][WORD_W-1];

endmodule

// File: rtl/ksa_wide_seq.sv
// Multi-cycle WORDS x 16-bit add/subtract sequencer around one shared
// Kogge-Stone slice. One word per cycle, LSW first, carry chained through
// a register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (accepted only in IDLE)
//   in_a, in_b, in_sub  : operands and op select (1 = A-B)
//   out_valid/out_ready : result handshake (held in DONE)
//   out_sum, out_co     : result mod 2^W and carry out (sub: 1 = no borrow)
//   out_ovf             : signed overflow
module ksa_wide_seq
  import ksa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] in_a,
  input  logic [WORD_W*WORDS-1:0] in_b,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] out_sum,
  output logic                    out_co,
  output logic                    out_ovf
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef logic [WORDS-1:0][WORD_W-1:0] wvec_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  wvec_t         a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          co_q, co_d, ovf_q, ovf_d;

  logic [WORD_W-1:0] a_w, b_w, s_w;
  logic              co_w;

  // Word-select muxes feeding the single adder instance.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (cnt_q == CW'(w)) begin
        a_w = a_q[w];
        b_w = b_q[w] ^ {WORD_W{sub_q}};
      end
    end
  end

  ksa_16bit u_add (
    .a  (a_w),
    .b  (b_w),
    .ci (carry_q),
    .s  (s_w),
    .co (co_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          carry_d = in_sub;  // +1 of the two's-complement negate
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int w = 0; w < WORDS; w++) begin
          if (cnt_q == CW'(w)) sum_d[w] = s_w;
        end
        carry_d = co_w;
        if (cnt_q == LAST) begin
          // Counter is held here so it never wraps.
          co_d    = co_w;
          ovf_d   = ovf_f(a_w[WORD_W-1], b_w[WORD_W-1], s_w[WORD_W-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_ksa_wide_seq.sv
module tb_ksa_wide_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WORDS=4 instance
  logic        in_valid4 = 1'b0, in_sub4 = 1'b0, out_ready4 = 1'b0;
  logic [63:0] in_a4 = '0, in_b4 = '0;
  logic        in_ready4, out_valid4, out_co4, out_ovf4;
  logic [63:0] out_sum4;

  // WORDS=1 instance
  logic        in_valid1 = 1'b0, in_sub1 = 1'b0, out_ready1 = 1'b0;
  logic [15:0] in_a1 = '0, in_b1 = '0;
  logic        in_ready1, out_valid1, out_co1, out_ovf1;
  logic [15:0] out_sum1;

  ksa_wide_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_sub(in_sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_co(out_co4), .out_ovf(out_ovf4)
  );

  ksa_wide_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_co(out_co1), .out_ovf(out_ovf1)
  );

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int checks = 0;
  int failures = 0;

  // Reference: plain w-bit arithmetic on whole operands.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input int w);
    logic [63:0] m, am, bx;
    logic [64:0] full;
    exp_t e;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & m;
    bx   = (sub ? ~b : b) & m;
    full = {1'b0, am} + {1'b0, bx} + {64'd0, sub};
    e.sum = full[63:0] & m;
    e.co  = full[w];
    e.ovf = (am[w-1] == bx[w-1]) && (e.sum[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic sub);
    @(negedge clk);
    in_a4 = a; in_b4 = b; in_sub4 = sub; in_valid4 = 1'b1;
    q4.push_back(model(a, b, sub, 64));
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic sub);
    @(negedge clk);
    in_a1 = a; in_b1 = b; in_sub1 = sub; in_valid1 = 1'b1;
    q1.push_back(model({48'd0, a}, {48'd0, b}, sub, 16));
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid (bounded).
  task automatic wait4(output int n);
    n = 0;
    while (!out_valid4 && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic wait1(output int n);
    n = 0;
    while (!out_valid1 && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic drain4();
    out_ready4 = 1'b1; @(negedge clk); out_ready4 = 1'b0;
  endtask

  task automatic drain1();
    out_ready1 = 1'b1; @(negedge clk); out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_sum4 !== 64'd0 ||
        out_co4 !== 1'b0 || out_ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL reset4: rdy=%b vld=%b sum=%h co=%b ovf=%b, want 1 0 0 0 0",
               in_ready4, out_valid4, out_sum4, out_co4, out_ovf4);
    end
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_sum1 !== 16'd0 ||
        out_co1 !== 1'b0 || out_ovf1 !== 1'b0) begin
      failures++;
      $display("FAIL reset1: rdy=%b vld=%b sum=%h co=%b ovf=%b, want 1 0 0 0 0",
               in_ready1, out_valid1, out_sum1, out_co1, out_ovf1);
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors4();
    logic [63:0] ta[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF,
                           64'h8000_0000_0000_0000, 64'h0001_FFFF_0000_FFFF,
                           64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF};
    logic [63:0] tb[7] = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h0000_0001_FFFF_0001,
                           64'hFEED_FACE_CAFE_BABE, 64'h0123_4567_89AB_CDEF};
    logic        ts[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int n;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      send4(ta[i], tb[i], ts[i]);
      wait4(n);
      checks++;
      if (n !== 4) begin
        failures++;
        $display("FAIL vec4[%0d] latency: got %0d edges, want 4", i, n);
      end
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL vec4[%0d] scoreboard empty", i);
      end else begin
        e = q4.pop_front();
        checks++;
        if (out_sum4 !== e.sum || out_co4 !== e.co || out_ovf4 !== e.ovf) begin
          failures++;
          $display("FAIL vec4[%0d] result: sum=%h co=%b ovf=%b, want sum=%h co=%b ovf=%b",
                   i, out_sum4, out_co4, out_ovf4, e.sum, e.co, e.ovf);
        end
      end
      drain4();
    end
  endtask

  task automatic test_backpressure();
    int n;
    exp_t e;
    send4(64'hA5A5_5A5A_F0F0_0F0F, 64'h1234_8765_FFFF_0001, 1'b0);
    wait4(n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL bp latency: got %0d edges, want 4", n);
    end
    e = q4.pop_front();
    for (int i = 0; i < 10; i++) begin
      in_valid4 = i[0];
      in_a4 = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || out_sum4 !== e.sum ||
          out_co4 !== e.co || out_ovf4 !== e.ovf) begin
        failures++;
        $display("FAIL bp hold[%0d]: vld=%b rdy=%b sum=%h co=%b ovf=%b, want 1 0 %h %b %b",
                 i, out_valid4, in_ready4, out_sum4, out_co4, out_ovf4, e.sum, e.co, e.ovf);
      end
    end
    in_valid4 = 1'b0;
    drain4();
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL bp release: vld=%b rdy=%b, want 0 1", out_valid4, in_ready4);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    exp_t e;
    send4(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    repeat (2) @(negedge clk);  // counter now 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q4.delete();  // aborted operation produces nothing
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_sum4 !== 64'd0 ||
        out_co4 !== 1'b0 || out_ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL midrst: rdy=%b vld=%b sum=%h co=%b ovf=%b, want 1 0 0 0 0",
               in_ready4, out_valid4, out_sum4, out_co4, out_ovf4);
    end
    send4(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    // Operand changes during RUN must be ignored.
    in_a4 = 64'hFFFF_FFFF_FFFF_FFFF; in_b4 = 64'hFFFF_FFFF_FFFF_FFFF; in_sub4 = 1'b1;
    wait4(n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL midrst latency: got %0d edges, want 4", n);
    end
    e = q4.pop_front();
    checks++;
    if (out_sum4 !== e.sum || out_co4 !== e.co || out_ovf4 !== e.ovf) begin
      failures++;
      $display("FAIL midrst result: sum=%h co=%b ovf=%b, want sum=%h co=%b ovf=%b",
               out_sum4, out_co4, out_ovf4, e.sum, e.co, e.ovf);
    end
    drain4();
  endtask

  task automatic test_words1();
    logic [15:0] ta[4] = '{16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000};
    logic [15:0] tb[4] = '{16'h0001, 16'h0003, 16'h0001, 16'h0001};
    logic        ts[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send1(ta[i], tb[i], ts[i]);
      wait1(n);
      checks++;
      if (n !== 1) begin
        failures++;
        $display("FAIL vec1[%0d] latency: got %0d edges, want 1", i, n);
      end
      e = q1.pop_front();
      checks++;
      if (out_sum1 !== e.sum[15:0] || out_co1 !== e.co || out_ovf1 !== e.ovf) begin
        failures++;
        $display("FAIL vec1[%0d] result: sum=%h co=%b ovf=%b, want sum=%h co=%b ovf=%b",
                 i, out_sum1, out_co1, out_ovf1, e.sum[15:0], e.co, e.ovf);
      end
      drain1();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send4({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      wait4(n);
      e = q4.pop_front();
      checks++;
      if (n !== 4 || out_sum4 !== e.sum || out_co4 !== e.co || out_ovf4 !== e.ovf) begin
        failures++;
        $display("FAIL b2b[%0d]: lat=%0d sum=%h co=%b ovf=%b, want 4 %h %b %b",
                 i, n, out_sum4, out_co4, out_ovf4, e.sum, e.co, e.ovf);
      end
      drain4();
    end
  endtask

  initial begin
    test_reset();
    test_vectors4();
    test_backpressure();
    test_reset_mid_run();
    test_words1();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
